md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the iterative signed multiply/divide sequencer.
// Holds the FSM encoding, the op encoding and the fixed-width sign helpers.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MD_ITER = 32;
    localparam int CNT_W   = $clog2(MD_ITER);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(MD_ITER - 1);

    // Two's-complement negate when sel is set, pass-through otherwise.
    function automatic logic [31:0] neg_sel32(input logic [31:0] v, input logic sel);
        return sel ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_sel64(input logic [63:0] v, input logic sel);
        return sel ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Iterative signed 32x32 multiply (shift-add) and divide (restoring) sequencer.
// Works on magnitudes for 32 cycles, then applies signs in a single FIX cycle.
module md_sequencer
    import md_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        hilo_write,
    output logic        div0
);

    md_state_e   state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div0_q, div0_d;

    logic        div_by_zero;
    logic [32:0] mul_sum;
    logic [33:0] div_shift;
    logic [33:0] div_diff;
    logic        div_fits;
    logic [63:0] prod_fix;

    assign div_by_zero = (op == OP_DIV) && (b == 32'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start && !div_by_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        hilo_write = (state_q == DONE);
        div0       = div0_q;
        hi         = hi_q;
        lo         = lo_q;
    end

    // ------------------------------------------------------------------
    // Datapath: one iteration step and the sign fix-up
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (LSB of the accumulator) is set, then shift right.
        mul_sum   = {1'b0, acc_q[63:32]} + ({1'b0, mag_a_q} & {33{acc_q[0]}});

        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract; a non-negative result means the quotient bit is 1.
        div_shift = {rem_q, acc_q[31]};
        div_diff  = div_shift - {2'b00, mag_b_q};
        div_fits  = ~div_diff[33];

        prod_fix  = neg_sel64(acc_q, sa_q ^ sb_q);
    end

    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = a[31];
                    sb_d    = b[31];
                    mag_a_d = neg_sel32(a, a[31]);
                    mag_b_d = neg_sel32(b, b[31]);
                    cnt_d   = '0;
                    rem_d   = '0;
                    // Multiply walks the multiplier out of the low half;
                    // divide walks the dividend out and the quotient in.
                    acc_d   = (op == OP_MULT) ? {32'd0, neg_sel32(b, b[31])}
                                              : {32'd0, neg_sel32(a, a[31])};
                    div0_d  = div_by_zero;
                end
            end
            RUN: begin
                cnt_d = cnt_q + cnt_t'(1);
                if (op_q == OP_MULT) begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end else begin
                    rem_d = div_fits ? div_diff[32:0] : div_shift[32:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], div_fits};
                end
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else begin
                    // Quotient follows sign(a)^sign(b); remainder follows the dividend.
                    lo_d = neg_sel32(acc_q[31:0], sa_q ^ sb_q);
                    hi_d = neg_sel32(rem_q[31:0], sa_q);
                end
            end
            DONE: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

endmodule
